game_score_ctrl: RTL and testbench

GAME_SCORE_CTRL -- requirements
Module: game_score_ctrl

---
 rtl/game_pkg.sv | 28 ++
 rtl/sat_digit_counter.sv | 39 +++
 rtl/game_score_ctrl.sv | 161 ++++++++++++++++
 tb/tb_game_score_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game score controller: FSM encoding,
// tune selection codes and the decimal-digit saturation helper.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_TUNE = 2'b10,
    ST_OVER = 2'b11
  } state_e;

  localparam logic [1:0] TUNE_NONE = 2'b00;
  localparam logic [1:0] TUNE_WIN  = 2'b01;
  localparam logic [1:0] TUNE_LOSE = 2'b10;

  localparam logic [3:0] MAX_DIGIT = 4'd9;

  function automatic logic [3:0] sat_inc(input logic [3:0] val);
    logic [3:0] res;
    if (val >= MAX_DIGIT) begin
      res = MAX_DIGIT;
    end else begin
      res = val + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_digit_counter.sv
// Single decimal digit counter that saturates at MAX_DIGIT; clear has priority
// over increment.
module sat_digit_counter
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] count
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // next-count selection
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 4'd0;
    end else if (inc) begin
      count_d = sat_inc(count_q);
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/game_score_ctrl.sv
// Game score controller: counts won/lost rounds, requests a tune per round and
// declares the game over at the configured limits. Define TUNE_TIMEOUT_EN to
// abandon a tune wait after TIMEOUT_CYCLES cycles.
module game_score_ctrl
  import game_pkg::*;
#(
  parameter int WIN_LIMIT      = 5,
  parameter int LOSE_LIMIT     = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       round_win,
  input  logic       round_lose,
  input  logic       tune_done,
  output logic       tune_req,
  output logic [1:0] tune_sel,
  output logic [3:0] win_cnt,
  output logic [3:0] lose_cnt,
  output logic       game_over,
  output logic       winner,
  output logic       tune_timeout
);

  localparam logic [3:0] WIN_LIM_C  = 4'(WIN_LIMIT);
  localparam logic [3:0] LOSE_LIM_C = 4'(LOSE_LIMIT);

  state_e     state_q;
  logic       tune_req_q;
  logic [1:0] tune_sel_q;
  logic       game_over_q;
  logic       winner_q;
  logic       tune_timeout_q;

  logic       clear_s;
  logic       inc_win_s;
  logic       inc_lose_s;
  logic       expire_s;
  logic       finish_s;

`ifdef TUNE_TIMEOUT_EN
  logic [31:0] timer_q;

  // cycles spent waiting in TUNE; idle at zero elsewhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= 32'd0;
    end else if (state_q == ST_TUNE) begin
      timer_q <= timer_q + 32'd1;
    end else begin
      timer_q <= 32'd0;
    end
  end

  assign expire_s = (state_q == ST_TUNE) && (timer_q == 32'(TIMEOUT_CYCLES - 1));
`else
  assign expire_s = 1'b0;
`endif

  // round events and clears feeding the digit counters
  always_comb begin
    clear_s    = start && ((state_q == ST_IDLE) || (state_q == ST_OVER));
    inc_lose_s = (state_q == ST_PLAY) && round_lose;
    inc_win_s  = (state_q == ST_PLAY) && round_win && !round_lose;
    finish_s   = (state_q == ST_TUNE) && (tune_done || expire_s);
  end

  sat_digit_counter u_win_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_s),
    .inc   (inc_win_s),
    .count (win_cnt)
  );

  sat_digit_counter u_lose_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_s),
    .inc   (inc_lose_s),
    .count (lose_cnt)
  );

  // main FSM with registered outputs; counts already include the latest round in TUNE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      tune_req_q     <= 1'b0;
      tune_sel_q     <= TUNE_NONE;
      game_over_q    <= 1'b0;
      winner_q       <= 1'b0;
      tune_timeout_q <= 1'b0;
    end else begin
      tune_timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_PLAY;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_PLAY: begin
          if (round_lose) begin
            tune_req_q <= 1'b1;
            tune_sel_q <= TUNE_LOSE;
            state_q    <= ST_TUNE;
          end else if (round_win) begin
            tune_req_q <= 1'b1;
            tune_sel_q <= TUNE_WIN;
            state_q    <= ST_TUNE;
          end else begin
            state_q <= ST_PLAY;
          end
        end
        ST_TUNE: begin
          if (finish_s) begin
            tune_req_q     <= 1'b0;
            tune_sel_q     <= TUNE_NONE;
            tune_timeout_q <= !tune_done;
            if (lose_cnt >= LOSE_LIM_C) begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
              winner_q    <= 1'b0;
            end else if (win_cnt >= WIN_LIM_C) begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
              winner_q    <= 1'b1;
            end else begin
              state_q <= ST_PLAY;
            end
          end else begin
            state_q <= ST_TUNE;
          end
        end
        ST_OVER: begin
          if (start) begin
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            state_q     <= ST_PLAY;
          end else begin
            state_q <= ST_OVER;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          tune_req_q <= 1'b0;
          tune_sel_q <= TUNE_NONE;
        end
      endcase
    end
  end

  assign tune_req     = tune_req_q;
  assign tune_sel     = tune_sel_q;
  assign game_over    = game_over_q;
  assign winner       = winner_q;
  assign tune_timeout = tune_timeout_q;

endmodule

// File: tb/tb_game_score_ctrl.sv
// Directed bench for game_score_ctrl: instance A uses default limits (5/3),
// instance B uses 9/9 for the saturation scenario.
module tb_game_score_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start_a = 1'b0, win_a = 1'b0, lose_a = 1'b0, done_a = 1'b0;
  logic       req_a, over_a, winner_a, to_a;
  logic [1:0] sel_a;
  logic [3:0] wcnt_a, lcnt_a;

  logic       start_b = 1'b0, win_b = 1'b0, lose_b = 1'b0, done_b = 1'b0;
  logic       req_b, over_b, winner_b, to_b;
  logic [1:0] sel_b;
  logic [3:0] wcnt_b, lcnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  game_score_ctrl #(.WIN_LIMIT(5), .LOSE_LIMIT(3), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .round_win(win_a),
    .round_lose(lose_a), .tune_done(done_a), .tune_req(req_a),
    .tune_sel(sel_a), .win_cnt(wcnt_a), .lose_cnt(lcnt_a),
    .game_over(over_a), .winner(winner_a), .tune_timeout(to_a)
  );

  game_score_ctrl #(.WIN_LIMIT(9), .LOSE_LIMIT(9), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .round_win(win_b),
    .round_lose(lose_b), .tune_done(done_b), .tune_req(req_b),
    .tune_sel(sel_b), .win_cnt(wcnt_b), .lose_cnt(lcnt_b),
    .game_over(over_b), .winner(winner_b), .tune_timeout(to_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0=start 1=win 2=lose 3=done 4=win+lose; one-cycle pulse on instance A
  task automatic pulse_a(input int ev);
    start_a = (ev == 0);
    win_a   = (ev == 1) || (ev == 4);
    lose_a  = (ev == 2) || (ev == 4);
    done_a  = (ev == 3);
    tick();
    start_a = 1'b0; win_a = 1'b0; lose_a = 1'b0; done_a = 1'b0;
  endtask

  task automatic pulse_b(input int ev);
    start_b = (ev == 0);
    win_b   = (ev == 1);
    lose_b  = (ev == 2);
    done_b  = (ev == 3);
    tick();
    start_b = 1'b0; win_b = 1'b0; lose_b = 1'b0; done_b = 1'b0;
  endtask

  initial begin
    // reset values while rst_n is low
    #2;
    check_val("rst_req", req_a, 0);
    check_val("rst_sel", sel_a, 0);
    check_val("rst_wcnt", wcnt_a, 0);
    check_val("rst_lcnt", lcnt_a, 0);
    check_val("rst_over", over_a, 0);
    check_val("rst_winner", winner_a, 0);
    check_val("rst_to", to_a, 0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // IDLE ignores rounds and tune_done
    pulse_a(1);
    check_val("idle_win_req", req_a, 0);
    check_val("idle_win_cnt", wcnt_a, 0);
    pulse_a(3);
    check_val("idle_done_req", req_a, 0);

    // start then a win
    pulse_a(0);
    pulse_a(1);
    check_val("win1_cnt", wcnt_a, 1);
    check_val("win1_req", req_a, 1);
    check_val("win1_sel", sel_a, 1);
    tick(); tick();
    pulse_a(0);
    pulse_a(2);
    check_val("tune_hold_req", req_a, 1);
    check_val("tune_hold_sel", sel_a, 1);
    check_val("tune_drop_lose", lcnt_a, 0);
`ifndef TUNE_TIMEOUT_EN
    for (int i = 0; i < 20; i++) tick();
    check_val("no_to_req", req_a, 1);
    check_val("no_to_pulse", to_a, 0);
`endif
    pulse_a(3);
    check_val("done1_req", req_a, 0);
    check_val("done1_sel", sel_a, 0);
    check_val("done1_over", over_a, 0);
    check_val("done1_wcnt", wcnt_a, 1);

    // simultaneous win+lose: lose takes precedence
    pulse_a(4);
    check_val("both_lcnt", lcnt_a, 1);
    check_val("both_wcnt", wcnt_a, 1);
    check_val("both_sel", sel_a, 2);
    pulse_a(3);
    pulse_a(2);
    pulse_a(3);
    check_val("lose2_over", over_a, 0);
    pulse_a(2);
    check_val("lose3_sel", sel_a, 2);
    pulse_a(3);
    check_val("lose3_over", over_a, 1);
    check_val("lose3_winner", winner_a, 0);
    check_val("lose3_lcnt", lcnt_a, 3);
    check_val("lose3_req", req_a, 0);
    pulse_a(1);
    check_val("over_win_cnt", wcnt_a, 1);
    check_val("over_win_req", req_a, 0);
    check_val("over_hold", over_a, 1);
    pulse_a(0);
    check_val("restart_wcnt", wcnt_a, 0);
    check_val("restart_lcnt", lcnt_a, 0);
    check_val("restart_over", over_a, 0);
    pulse_a(1);
    check_val("restart_play", req_a, 1);
    pulse_a(3);

    // play to a win at WIN_LIMIT=5
    for (int i = 2; i <= 5; i++) begin
      pulse_a(1);
      pulse_a(3);
    end
    check_val("win5_cnt", wcnt_a, 5);
    check_val("win5_over", over_a, 1);
    check_val("win5_winner", winner_a, 1);
    pulse_a(0);
    check_val("win5_restart_winner", winner_a, 0);

`ifdef TUNE_TIMEOUT_EN
    pulse_a(1);
    for (int i = 0; i < 7; i++) tick();
    check_val("to_pre_req", req_a, 1);
    check_val("to_pre_pulse", to_a, 0);
    tick();
    check_val("to_req", req_a, 0);
    check_val("to_pulse", to_a, 1);
    tick();
    check_val("to_pulse_end", to_a, 0);
    pulse_a(2);
    check_val("to_back_play", req_a, 1);
    for (int i = 0; i < 7; i++) tick();
    pulse_a(3);
    check_val("to_edge_req", req_a, 0);
    check_val("to_edge_pulse", to_a, 0);
    tick();
    check_val("to_edge_pulse2", to_a, 0);
`endif

    // asynchronous reset in TUNE
    pulse_a(1);
    check_val("pre_rst_req", req_a, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_req", req_a, 0);
    check_val("arst_wcnt", wcnt_a, 0);
    check_val("arst_lcnt", lcnt_a, 0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    pulse_a(1);
    check_val("post_rst_idle", req_a, 0);
    check_val("post_rst_wcnt", wcnt_a, 0);

    // instance B: 9 wins with saturation limit 9
    pulse_b(0);
    for (int i = 1; i <= 9; i++) begin
      pulse_b(1);
      check_val($sformatf("b_win%0d", i), wcnt_b, i);
      if (i == 9) begin
        pulse_b(1);
        check_val("b_tune_drop", wcnt_b, 9);
        check_val("b_tune_req", req_b, 1);
      end
      pulse_b(3);
      check_val($sformatf("b_done%0d", i), wcnt_b, i);
    end
    check_val("b_over", over_b, 1);
    check_val("b_winner", winner_b, 1);
    pulse_b(1);
    check_val("b_over_win", wcnt_b, 9);
    check_val("b_lcnt", lcnt_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
